// File: rtl/hex_scroller.sv
// -----------------------------------------------------------------------------
// hex_scroller
//
// Scrolling-message driver for a bank of active-low 7-segment displays.
// A writable buffer of MSG_LEN 4-bit character codes is rotated across DIGITS
// displays. It advances one position per prescaler tick (while Run=1) or per
// Step pulse.
//
// Optional feature macro: HEX_SCROLLER_DIR_EN
//   defined   -> Dir selects the scroll direction (0 = left, 1 = right)
//   undefined -> scrolling is always left; the Dir port exists but is unused
//
// Parameters
//   DIGITS   number of displays driven (1..8)
//   MSG_LEN  message buffer depth (2..16)
//   TICK_DIV clock cycles per automatic scroll step (>= 2)
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-high reset
//   Run      in   1 = automatic scrolling, 0 = paused (prescaler held at 0)
//   Step     in   single-cycle pulse, advances one position in either state
//   Dir      in   scroll direction (only with HEX_SCROLLER_DIR_EN)
//   Clear    in   synchronous clear: buffer blank, Pos 0, prescaler 0
//   Wr_en    in   buffer write strobe
//   Wr_addr  in   buffer slot; slots >= MSG_LEN are ignored
//   Wr_char  in   character code (0-9, A, b, C, d, E, F = blank)
//   Pos      out  current scroll position 0..MSG_LEN-1
//   HEX      out  registered segment drive, active-low; digit k in
//                 [7k+6:7k] ordered a..g, digit 0 rightmost
// -----------------------------------------------------------------------------
module hex_scroller #(
   parameter int DIGITS   = 6,
   parameter int MSG_LEN  = 6,
   parameter int TICK_DIV = 50000000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic                  Step,
   input  logic                  Dir,
   input  logic                  Clear,
   input  logic                  Wr_en,
   input  logic [3:0]            Wr_addr,
   input  logic [3:0]            Wr_char,
   output logic [3:0]            Pos,
   output logic [7*DIGITS-1:0]   HEX
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [3:0] POS_MAX = 4'(MSG_LEN - 1);
   // Buffer is sized to a power of two so it can be indexed with a plain
   // AW-bit address. Slots at or above MSG_LEN are never written or read.
   localparam int AW    = $clog2(MSG_LEN);
   localparam int DEPTH = 2 ** AW;
   localparam logic [3:0] BLANK = 4'hF;

   typedef enum logic {
      PAUSED  = 1'b0,
      RUNNING = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_nxt;

   logic [CNT_W-1:0]    cnt_q;
   logic                cnt_en;
   logic                tick;
   logic                advance;
   logic                scroll_right;
   logic [3:0]          pos_q;
   logic [3:0]          pos_nxt;
   logic [3:0]          buf_q [DEPTH];
   logic                wr_hit;
   logic [AW-1:0]       wr_idx;
   logic [AW-1:0]       rd_idx;
   logic [7*DIGITS-1:0] hex_nxt;
   logic [7*DIGITS-1:0] hex_p1;

   // Character code to active-low segments {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg7(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

`ifdef HEX_SCROLLER_DIR_EN
   assign scroll_right = Dir;
`else
   logic unused_dir;
   assign unused_dir   = Dir;
   assign scroll_right = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Run/pause control: state register, next state, outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= PAUSED;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = Run ? RUNNING : PAUSED;
   end

   // Coming out of PAUSED the prescaler is known to sit at 0, and TICK_DIV >= 2,
   // so no tick can occur in that cycle; only the count needs enabling.
   always_comb begin
      cnt_en = 1'b0;
      tick   = 1'b0;
      case (state_q)
         PAUSED: begin
            cnt_en = Run;
         end
         default: begin
            cnt_en = Run;
            tick   = Run && (cnt_q == CNT_MAX);
         end
      endcase
   end

   assign advance = tick | Step;

   always_comb begin
      pos_nxt = pos_q;
      if (advance) begin
         if (scroll_right) begin
            pos_nxt = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
         end else begin
            pos_nxt = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
         end
      end
   end

   assign wr_hit = Wr_en && (int'(Wr_addr) < MSG_LEN);
   assign wr_idx = Wr_addr[AW-1:0];

   // ---------------------------------------------------------------------------
   // Stage 0: prescaler, position and message buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt_q <= '0;
         pos_q <= 4'd0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= BLANK;
         end
      end else if (Clear) begin
         cnt_q <= '0;
         pos_q <= 4'd0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= BLANK;
         end
      end else begin
         if (!cnt_en || tick) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         pos_q <= pos_nxt;
         if (wr_hit) begin
            buf_q[wr_idx] <= Wr_char;
         end
      end
   end

   // Digit k shows buffer[(pos + DIGITS-1-k) mod MSG_LEN]
   always_comb begin
      hex_nxt = '1;
      rd_idx  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         rd_idx = AW'((int'(pos_q) + DIGITS - 1 - k) % MSG_LEN);
         hex_nxt[7*k +: 7] = seg7(buf_q[rd_idx]);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: registered segment drive
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hex_p1 <= '1;
      end else begin
         hex_p1 <= hex_nxt;
      end
   end

   assign Pos = pos_q;
   assign HEX = hex_p1;

endmodule
